// File: rtl/rv_fwd_pkg.sv
// Shared encodings and tag record for the EX-stage operand forwarding controller.
// Consumed by forward_select_ctrl (optional forwarding under FWD_CTRL_FORWARDING_EN).
package rv_fwd_pkg;

    localparam int SEL_WIDTH      = 3;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [SEL_WIDTH-1:0] {
        SEL_RF      = 3'b000,
        SEL_EX_ALU  = 3'b001,
        SEL_WB_ALU  = 3'b010,
        SEL_WB_LOAD = 3'b011,
        SEL_PC      = 3'b100,
        SEL_IMM     = 3'b101
    } sel_e;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // x0 is hardwired zero, so a producer of x0 never matches a consumer.
    function automatic logic tag_hit(input tag_t t, input logic [REG_ADDR_WIDTH-1:0] src);
        return t.valid && t.reg_write && (t.rd != '0) && (t.rd == src);
    endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One pipeline tag register: holds on freeze, loads a bubble on request,
// and clears asynchronously on reset.
module fwd_tag_stage
    import rv_fwd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= TAG_BUBBLE;
        end else if (!hold) begin
            q <= bubble ? TAG_BUBBLE : d;
        end
    end

endmodule

// File: rtl/forward_select_ctrl.sv
// Operand-select and hazard-stall controller for the EX stage.
// Define FWD_CTRL_FORWARDING_EN to enable bypassing; otherwise hazards stall until clear.
module forward_select_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SEL_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_id,
    input  logic                      reg_write_id,
    input  logic                      mem_read_id,
    input  logic                      use_pc_id,
    input  logic                      use_imm_id,
    input  logic                      stall_in,
    input  logic                      flush,
    output logic [SEL_WIDTH-1:0]      sel_a,
    output logic [SEL_WIDTH-1:0]      sel_b,
    output logic                      stall_out
);

    typedef rv_fwd_pkg::tag_t tag_t;

    tag_t                 id_tag, ex_q, mem_q, wb_q;
    logic                 ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
    logic                 used_a, used_b, bubble;
    logic [SEL_WIDTH-1:0] next_a, next_b;

    assign id_tag = '{valid: 1'b1, rd: rd_id, reg_write: reg_write_id, mem_read: mem_read_id};

    assign ex_a  = rv_fwd_pkg::tag_hit(ex_q,  rs1_id);
    assign mem_a = rv_fwd_pkg::tag_hit(mem_q, rs1_id);
    assign wb_a  = rv_fwd_pkg::tag_hit(wb_q,  rs1_id);
    assign ex_b  = rv_fwd_pkg::tag_hit(ex_q,  rs2_id);
    assign mem_b = rv_fwd_pkg::tag_hit(mem_q, rs2_id);
    assign wb_b  = rv_fwd_pkg::tag_hit(wb_q,  rs2_id);

    assign used_a = !use_pc_id;
    assign used_b = !use_imm_id;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_a    = rv_fwd_pkg::SEL_RF;
        next_b    = rv_fwd_pkg::SEL_RF;
        stall_out = 1'b0;
`ifdef FWD_CTRL_FORWARDING_EN
        // WB producers read through the register file (write-before-read).
        if (ex_a)       next_a = rv_fwd_pkg::SEL_EX_ALU;
        else if (mem_a) next_a = mem_q.mem_read ? rv_fwd_pkg::SEL_WB_LOAD : rv_fwd_pkg::SEL_WB_ALU;
        else if (wb_a)  next_a = rv_fwd_pkg::SEL_RF;

        if (ex_b)       next_b = rv_fwd_pkg::SEL_EX_ALU;
        else if (mem_b) next_b = mem_q.mem_read ? rv_fwd_pkg::SEL_WB_LOAD : rv_fwd_pkg::SEL_WB_ALU;
        else if (wb_b)  next_b = rv_fwd_pkg::SEL_RF;

        stall_out = ex_q.mem_read && ((used_a && ex_a) || (used_b && ex_b));
`else
        stall_out = (used_a && (ex_a || mem_a || (wb_a && 1'b0)))
                 || (used_b && (ex_b || mem_b || (wb_b && 1'b0)));
`endif
        if (use_pc_id)  next_a = rv_fwd_pkg::SEL_PC;
        if (use_imm_id) next_b = rv_fwd_pkg::SEL_IMM;
    end

    assign bubble = stall_out || flush;

    fwd_tag_stage u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (stall_in),
        .bubble (bubble),
        .d      (id_tag),
        .q      (ex_q)
    );

    fwd_tag_stage u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (stall_in),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    fwd_tag_stage u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (stall_in),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // A bubble entering EX carries neutral selects so it cannot consume a bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a <= '0;
            sel_b <= '0;
        end else if (!stall_in) begin
            sel_a <= bubble ? SEL_WIDTH'(rv_fwd_pkg::SEL_RF) : next_a;
            sel_b <= bubble ? SEL_WIDTH'(rv_fwd_pkg::SEL_RF) : next_b;
        end
    end

endmodule

// File: tb/tb_forward_select_ctrl.sv
// Self-checking bench for forward_select_ctrl: directed vector table, reset-mid-stall
// sequence, and randomized traffic against an in-flight-producer model.
module tb_forward_select_ctrl;

`ifdef FWD_CTRL_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       reg_write_id, mem_read_id, use_pc_id, use_imm_id, stall_in, flush;
    logic [2:0] sel_a, sel_b;
    logic       stall_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    forward_select_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rd_id        (rd_id),
        .reg_write_id (reg_write_id),
        .mem_read_id  (mem_read_id),
        .use_pc_id    (use_pc_id),
        .use_imm_id   (use_imm_id),
        .stall_in     (stall_in),
        .flush        (flush),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .stall_out    (stall_out)
    );

    // ID inputs, then expected stall_out this cycle and selects after the edge.
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr, pc, imm, sin, fl;
        logic       es;
        logic [2:0] ea, eb;
    } vec_t;

    vec_t tbl[$];

    // Model: instructions in flight, index 0 = youngest (in EX).
    typedef struct { bit v; int rd; bit rw; bit mr; } minst_t;
    minst_t pipe[3];
    int     msel_a, msel_b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_id = v.rs1; rs2_id = v.rs2; rd_id = v.rd;
        reg_write_id = v.rw; mem_read_id = v.mr;
        use_pc_id = v.pc; use_imm_id = v.imm;
        stall_in = v.sin; flush = v.fl;
    endtask

    task automatic run_cycle(input string nm, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check({nm, ".stall_out"}, 32'(stall_out), 32'(v.es));
        @(posedge clk);
        #1;
        check({nm, ".sel_a"}, 32'(sel_a), 32'(v.ea));
        check({nm, ".sel_b"}, 32'(sel_b), 32'(v.eb));
    endtask

    function automatic int youngest(input int src);
        if (src == 0) return 3;
        for (int k = 0; k < 3; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].rd == src) return k;
        return 3;
    endfunction

    function automatic int src_sel(input int src);
        int k = youngest(src);
        if (!FWD) return 0;
        if (k == 0) return 1;
        if (k == 1) return pipe[1].mr ? 3 : 2;
        return 0;
    endfunction

    function automatic bit src_stall(input int src);
        int k = youngest(src);
        if (FWD) return (k == 0) && pipe[0].mr;
        return k <= 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        msel_a = 0;
        msel_b = 0;
    endtask

    // Fills in v's expectations from the model and advances the model one edge.
    task automatic model_step(inout vec_t v);
        bit st;
        st = (!v.pc && src_stall(v.rs1)) || (!v.imm && src_stall(v.rs2));
        v.es = st;
        if (!v.sin) begin
            msel_a = (st || v.fl) ? 0 : (v.pc  ? 4 : src_sel(v.rs1));
            msel_b = (st || v.fl) ? 0 : (v.imm ? 5 : src_sel(v.rs2));
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (st || v.fl) ? '{0, 0, 0, 0} : '{1, int'(v.rd), v.rw, v.mr};
        end
        v.ea = 3'(msel_a);
        v.eb = 3'(msel_b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        #1;
        check("reset.stall_out", 32'(stall_out), 0);
        check("reset.sel_a", 32'(sel_a), 0);
        check("reset.sel_b", 32'(sel_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (2) @(posedge clk);
        do_reset();

`ifdef FWD_CTRL_FORWARDING_EN
        tbl.push_back('{1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // add x5
        tbl.push_back('{5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0});   // add x6,x5,x1 -> EX bypass
        tbl.push_back('{3, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0, 5});   // lw x7
        tbl.push_back('{7, 7, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0});   // load-use: stall, bubble
        tbl.push_back('{7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 3, 3});   // load data from MEM/WB
        tbl.push_back('{1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // add x0
        tbl.push_back('{0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // use x0: no forward
        tbl.push_back('{1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // second x9 writer
        tbl.push_back('{9, 3, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0});  // youngest x9 wins
        tbl.push_back('{10, 0, 11, 1, 0, 1, 1, 0, 0, 0, 4, 5}); // auipc overrides bypass
        tbl.push_back('{11, 0, 12, 1, 1, 0, 1, 0, 0, 0, 1, 5}); // lw x12
        tbl.push_back('{12, 1, 13, 1, 0, 0, 0, 0, 1, 1, 0, 0}); // hazard + flush
        tbl.push_back('{12, 1, 13, 1, 0, 0, 0, 0, 0, 0, 3, 0}); // stall dropped
        tbl.push_back('{1, 0, 14, 1, 1, 0, 1, 0, 0, 0, 0, 5});  // lw x14
        tbl.push_back('{14, 14, 15, 1, 0, 0, 0, 1, 0, 1, 0, 5}); // freeze wins over bubble
        tbl.push_back('{14, 14, 15, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{14, 14, 15, 1, 0, 0, 0, 0, 0, 0, 3, 3});
        tbl.push_back('{1, 2, 16, 1, 0, 0, 0, 1, 1, 0, 3, 3});  // flush ignored while frozen
        tbl.push_back('{15, 2, 17, 1, 0, 0, 0, 0, 0, 0, 1, 0}); // x15 still in EX
`else
        tbl.push_back('{1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // add x5
        tbl.push_back('{5, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0});   // match in EX
        tbl.push_back('{5, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0});   // match in MEM
        tbl.push_back('{5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // WB only: go
        tbl.push_back('{3, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0, 5});   // lw x7
        tbl.push_back('{7, 7, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{7, 7, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{8, 8, 9, 1, 0, 1, 1, 0, 0, 0, 4, 5});   // both operands overridden
        tbl.push_back('{1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // add x0
        tbl.push_back('{0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0});  // use x0: no stall
        tbl.push_back('{10, 1, 11, 1, 0, 0, 0, 0, 1, 1, 0, 0}); // hazard + flush
        tbl.push_back('{10, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{11, 0, 12, 1, 0, 0, 0, 1, 0, 1, 0, 0}); // frozen: no bubble
        tbl.push_back('{11, 0, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{11, 0, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{11, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0});
`endif
        foreach (tbl[i]) run_cycle($sformatf("vec%0d", i), tbl[i]);

        // Reset pulsed while a load-use stall is pending.
        do_reset();
        run_cycle("rst_lw", '{1, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0, 5});
        @(negedge clk);
        drive('{7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        #1;
        check("rst_mid.stall_before", 32'(stall_out), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.stall_out", 32'(stall_out), 0);
        check("rst_mid.sel_a", 32'(sel_a), 0);
        check("rst_mid.sel_b", 32'(sel_b), 0);
        @(posedge clk);
        #1;
        check("rst_hold.sel_b", 32'(sel_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("rst_resume", '{7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        if (FWD) run_cycle("rst_next", '{8, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0});
        else     run_cycle("rst_next", '{8, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0});

        // Randomized traffic over a small register range to provoke hazards.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.rw  = ($urandom_range(0, 9) < 8);
            v.mr  = ($urandom_range(0, 9) < 3);
            v.pc  = ($urandom_range(0, 9) < 2);
            v.imm = ($urandom_range(0, 9) < 3);
            v.sin = ($urandom_range(0, 9) < 2);
            v.fl  = ($urandom_range(0, 9) < 1);
            model_step(v);
            run_cycle($sformatf("rnd%0d", n), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
